// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: load-use stalls, EX redirect flushes, imem wait bubbles.
// Controls are Mealy (same cycle as inputs); state, bubble counter and perf counters are registered.
module hazard_control_unit #(
   parameter int unsigned FLUSH_EXTRA = 0,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic             imem_ready,
   output logic             pc_write,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

   localparam logic [3:0]       RELOAD   = 4'(FLUSH_EXTRA);
   localparam logic [CNT_W-1:0] CNT_ONE  = 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t     state, next_state;
   logic [3:0] bcnt, bcnt_next;
   logic       lu;

   assign lu = ex_mem_read && (ex_rd != 5'd0) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RUN;
         bcnt  <= 4'd0;
      end else begin
         state <= next_state;
         bcnt  <= bcnt_next;
      end
   end

   always_comb begin
      next_state = state;
      bcnt_next  = bcnt;
      unique case (state)
         RUN: begin
            if (ex_branch_taken && (RELOAD != 4'd0)) begin
               next_state = FLUSH;
               bcnt_next  = RELOAD;
            end
         end
         default: begin
            if (ex_branch_taken) begin
               next_state = (RELOAD != 4'd0) ? FLUSH : RUN;
               bcnt_next  = RELOAD;
            end else if (imem_ready) begin
               // Last bubble consumed: return to RUN rather than sit at zero.
               if (bcnt <= 4'd1) begin
                  next_state = RUN;
                  bcnt_next  = 4'd0;
               end else begin
                  bcnt_next  = bcnt - 4'd1;
               end
            end
         end
      endcase
   end

   always_comb begin
      pc_write    = 1'b0;
      if_id_stall = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      if (!reset) begin
         if (ex_branch_taken) begin
            pc_write    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (state == FLUSH) begin
            // ID holds only bubbles here, so a load-use match is irrelevant.
            pc_write    = imem_ready;
            if_id_flush = 1'b1;
         end else if (lu) begin
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
         end else if (!imem_ready) begin
            if_id_flush = 1'b1;
         end else begin
            pc_write    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (!pc_write && (stall_count != CNT_MAX))
            stall_count <= stall_count + CNT_ONE;
         if (ex_branch_taken && (flush_count != CNT_MAX))
            flush_count <= flush_count + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench: FLUSH_EXTRA=2/CNT_W=4 instance plus a default-parameter instance on the same inputs.
module tb_hazard_control_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, imem_ready;
   logic        pc_write, if_id_stall, if_id_flush, id_ex_flush;
   logic [3:0]  stall_count, flush_count;
   logic        pc_write0, if_id_stall0, if_id_flush0, id_ex_flush0;
   logic [31:0] stall_count0, flush_count0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   hazard_control_unit #(.FLUSH_EXTRA(2), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
      .pc_write(pc_write), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
      .id_ex_flush(id_ex_flush), .stall_count(stall_count), .flush_count(flush_count)
   );

   hazard_control_unit dut0 (
      .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
      .pc_write(pc_write0), .if_id_stall(if_id_stall0), .if_id_flush(if_id_flush0),
      .id_ex_flush(id_ex_flush0), .stall_count(stall_count0), .flush_count(flush_count0)
   );

   task automatic idle();
      id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
      ex_branch_taken = 1'b0; imem_ready = 1'b1;
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      #1;
      n_cmp++; if ({pc_write, if_id_stall, if_id_flush, id_ex_flush} !== 4'b0000) begin
         n_bad++; $display("FAIL reset_ctl: got %b want 0000", {pc_write, if_id_stall, if_id_flush, id_ex_flush}); end
      n_cmp++; if ({stall_count, flush_count} !== 8'h00) begin
         n_bad++; $display("FAIL reset_cnt: got %h want 00", {stall_count, flush_count}); end
      cyc();
      reset = 1'b0;
      #1;
      n_cmp++; if ({pc_write, if_id_stall, if_id_flush, id_ex_flush} !== 4'b1000) begin
         n_bad++; $display("FAIL reset_release: got %b want 1000", {pc_write, if_id_stall, if_id_flush, id_ex_flush}); end
   endtask

   task automatic test_load_use();
      do_reset();
      ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
      #1;
      n_cmp++; if ({pc_write, if_id_stall, if_id_flush, id_ex_flush} !== 4'b0101) begin
         n_bad++; $display("FAIL lu_ctl: got %b want 0101", {pc_write, if_id_stall, if_id_flush, id_ex_flush}); end
      cyc();
      idle();
      #1;
      n_cmp++; if ({pc_write, if_id_stall, if_id_flush, id_ex_flush} !== 4'b1000) begin
         n_bad++; $display("FAIL lu_after: got %b want 1000", {pc_write, if_id_stall, if_id_flush, id_ex_flush}); end
      n_cmp++; if (stall_count !== 4'd1) begin
         n_bad++; $display("FAIL lu_stall_count: got %0d want 1", stall_count); end
   endtask

   task automatic test_no_hazard();
      do_reset();
      ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
      #1;
      n_cmp++; if ({pc_write, if_id_stall} !== 2'b10) begin
         n_bad++; $display("FAIL x0_no_stall: got %b want 10", {pc_write, if_id_stall}); end
      ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_uses_rs2 = 1'b0;
      #1;
      n_cmp++; if ({pc_write, if_id_stall} !== 2'b10) begin
         n_bad++; $display("FAIL unused_rs2: got %b want 10", {pc_write, if_id_stall}); end
      id_uses_rs2 = 1'b1;
      #1;
      n_cmp++; if ({pc_write, if_id_stall, id_ex_flush} !== 3'b011) begin
         n_bad++; $display("FAIL rs2_hazard: got %b want 011", {pc_write, if_id_stall, id_ex_flush}); end
      idle();
   endtask

   task automatic test_redirect();
      do_reset();
      ex_branch_taken = 1'b1;
      #1;
      n_cmp++; if ({pc_write, if_id_flush, id_ex_flush, if_id_flush0} !== 4'b1111) begin
         n_bad++; $display("FAIL redir_c0: got %b want 1111", {pc_write, if_id_flush, id_ex_flush, if_id_flush0}); end
      cyc();
      ex_branch_taken = 1'b0;
      #1;
      n_cmp++; if ({pc_write, if_id_flush, id_ex_flush, if_id_flush0, pc_write0} !== 5'b11001) begin
         n_bad++; $display("FAIL redir_c1: got %b want 11001", {pc_write, if_id_flush, id_ex_flush, if_id_flush0, pc_write0}); end
      cyc();
      n_cmp++; if ({pc_write, if_id_flush, id_ex_flush} !== 3'b110) begin
         n_bad++; $display("FAIL redir_c2: got %b want 110", {pc_write, if_id_flush, id_ex_flush}); end
      cyc();
      n_cmp++; if ({pc_write, if_id_flush, id_ex_flush} !== 3'b100) begin
         n_bad++; $display("FAIL redir_c3: got %b want 100", {pc_write, if_id_flush, id_ex_flush}); end
      n_cmp++; if ({flush_count, stall_count} !== 8'h10) begin
         n_bad++; $display("FAIL redir_counts: got %h want 10", {flush_count, stall_count}); end
   endtask

   task automatic test_branch_lu();
      do_reset();
      ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
      #1;
      n_cmp++; if ({pc_write, if_id_stall, if_id_flush, id_ex_flush} !== 4'b1011) begin
         n_bad++; $display("FAIL br_lu: got %b want 1011", {pc_write, if_id_stall, if_id_flush, id_ex_flush}); end
      cyc();
      ex_branch_taken = 1'b0;
      #1;
      n_cmp++; if ({pc_write, if_id_stall, if_id_flush, id_ex_flush} !== 4'b1010) begin
         n_bad++; $display("FAIL lu_in_flush: got %b want 1010", {pc_write, if_id_stall, if_id_flush, id_ex_flush}); end
      idle();
   endtask

   task automatic test_imem_wait();
      do_reset();
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if ({pc_write, if_id_stall, if_id_flush, id_ex_flush} !== 4'b0010) begin
            n_bad++; $display("FAIL imem_wait[%0d]: got %b want 0010", i, {pc_write, if_id_stall, if_id_flush, id_ex_flush}); end
         cyc();
      end
      imem_ready = 1'b1;
      #1;
      n_cmp++; if ({stall_count, pc_write} !== 5'b0011_1) begin
         n_bad++; $display("FAIL imem_stall_count: got %0d/%b want 3/1", stall_count, pc_write); end
   endtask

   task automatic test_flush_wait();
      do_reset();
      ex_branch_taken = 1'b1;
      cyc();
      ex_branch_taken = 1'b0; imem_ready = 1'b0;
      #1;
      n_cmp++; if ({pc_write, if_id_flush} !== 2'b01) begin
         n_bad++; $display("FAIL fw_hold: got %b want 01", {pc_write, if_id_flush}); end
      cyc();
      imem_ready = 1'b1;
      #1;
      n_cmp++; if ({pc_write, if_id_flush} !== 2'b11) begin
         n_bad++; $display("FAIL fw_c2: got %b want 11", {pc_write, if_id_flush}); end
      cyc();
      n_cmp++; if (if_id_flush !== 1'b1) begin
         n_bad++; $display("FAIL fw_c3: got %b want 1", if_id_flush); end
      cyc();
      n_cmp++; if ({if_id_flush, stall_count} !== 5'b0_0001) begin
         n_bad++; $display("FAIL fw_end: got %b want 00001", {if_id_flush, stall_count}); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      ex_branch_taken = 1'b1;
      cyc();
      #1;
      n_cmp++; if ({pc_write, if_id_flush, id_ex_flush} !== 3'b111) begin
         n_bad++; $display("FAIL b2b_second: got %b want 111", {pc_write, if_id_flush, id_ex_flush}); end
      cyc();
      ex_branch_taken = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_cmp++; if ({if_id_flush, id_ex_flush} !== 2'b10) begin
            n_bad++; $display("FAIL b2b_bubble[%0d]: got %b want 10", i, {if_id_flush, id_ex_flush}); end
         cyc();
      end
      n_cmp++; if ({if_id_flush, flush_count} !== 5'b0_0010) begin
         n_bad++; $display("FAIL b2b_end: got %b want 00010", {if_id_flush, flush_count}); end
   endtask

   task automatic test_reset_mid_flush();
      do_reset();
      ex_branch_taken = 1'b1;
      cyc();
      ex_branch_taken = 1'b0;
      cyc();
      reset = 1'b1;
      #1;
      n_cmp++; if ({pc_write, if_id_stall, if_id_flush, id_ex_flush, stall_count, flush_count} !== 12'h000) begin
         n_bad++; $display("FAIL rst_mid_flush: got %h want 000",
                           {pc_write, if_id_stall, if_id_flush, id_ex_flush, stall_count, flush_count}); end
      cyc();
      reset = 1'b0;
      #1;
      n_cmp++; if ({pc_write, if_id_flush} !== 2'b10) begin
         n_bad++; $display("FAIL rst_abandon: got %b want 10", {pc_write, if_id_flush}); end
   endtask

   task automatic test_saturation();
      do_reset();
      imem_ready = 1'b0;
      for (int i = 0; i < 14; i++) cyc();
      n_cmp++; if (stall_count !== 4'd14) begin
         n_bad++; $display("FAIL sat_14: got %0d want 14", stall_count); end
      for (int i = 0; i < 6; i++) cyc();
      n_cmp++; if (stall_count !== 4'd15) begin
         n_bad++; $display("FAIL sat_hold: got %0d want 15", stall_count); end
      n_cmp++; if (stall_count0 !== 32'd20) begin
         n_bad++; $display("FAIL wide_count: got %0d want 20", stall_count0); end
      idle();
   endtask

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_load_use();
      test_no_hazard();
      test_redirect();
      test_branch_lu();
      test_imem_wait();
      test_flush_wait();
      test_back_to_back();
      test_reset_mid_flush();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
